// File: rtl/pes_arith_pkg.sv
`default_nettype none
// ============================================================================
// Module      : pes_arith_pkg
// Description : Shared constants and state encoding for the pes_* serial
//               arithmetic blocks (pes_rca adder, pes_rcs subtractor).
// Revision    : 1.0 - initial release
// ============================================================================
package pes_arith_pkg;

    localparam int c_def_width = 16;
    localparam int c_def_digit = 4;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } pes_state_t;

endpackage : pes_arith_pkg
`default_nettype wire

// File: rtl/pes_digit_sub.sv
`default_nettype none
// ============================================================================
// Module      : pes_digit_sub
// Description : Combinational DIGIT-bit subtractor slice.
//               {bout, d} = a - b - bin, bout set when the slice borrows.
// Revision    : 1.0 - initial release
// ============================================================================
module pes_digit_sub #(
    parameter int DIGIT = 4
) (
    input  logic [DIGIT-1:0] a,
    input  logic [DIGIT-1:0] b,
    input  logic             bin,
    output logic [DIGIT-1:0] d,
    output logic             bout
);

    // One extra bit on the left captures the borrow as the wrapped sign bit.
    assign {bout, d} = {1'b0, a} - {1'b0, b} - {{DIGIT{1'b0}}, bin};

endmodule : pes_digit_sub
`default_nettype wire

// File: rtl/pes_rcs.sv
`default_nettype none
// ============================================================================
// Module      : pes_rcs
// Description : Multi-cycle ripple-borrow subtractor. Computes
//               diff = a - b - bin and bout, DIGIT bits per clock from LSB to
//               MSB, with valid/ready handshakes on both sides.
// Revision    : 1.0 - initial release
// ============================================================================
import pes_arith_pkg::*;

module pes_rcs #(
    parameter int WIDTH = c_def_width,
    parameter int DIGIT = c_def_digit
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             bin,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] diff,
    output logic             bout
);

    localparam int NDIG = WIDTH / DIGIT;
    localparam int CW   = (NDIG > 1) ? $clog2(NDIG) : 1;
    localparam logic [CW-1:0] c_last = CW'(NDIG - 1);

    // Refuse to elaborate a width that does not split into whole digits.
    generate
        if ((WIDTH % DIGIT) != 0) begin : g_cfg_check
            $error("pes_rcs: WIDTH must be a multiple of DIGIT");
        end
    endgenerate

    pes_state_t      r_state;
    pes_state_t      w_next;

    logic [WIDTH-1:0] r_a;
    logic [WIDTH-1:0] r_b;
    logic [WIDTH-1:0] r_acc;
    logic [WIDTH-1:0] r_diff;
    logic             r_borrow;
    logic             r_bout;
    logic [CW-1:0]    r_cnt;

    logic [DIGIT-1:0] w_d;
    logic             w_bout_dig;
    logic [WIDTH-1:0] w_acc_next;
    logic             w_last;

    pes_digit_sub #(
        .DIGIT (DIGIT)
    ) u_digit_sub (
        .a    (r_a[DIGIT-1:0]),
        .b    (r_b[DIGIT-1:0]),
        .bin  (r_borrow),
        .d    (w_d),
        .bout (w_bout_dig)
    );

    // New digit enters the result accumulator from the top so that after
    // NDIG steps the first (least significant) digit sits at bit 0.
    generate
        if (NDIG == 1) begin : g_single_digit
            assign w_acc_next = w_d;
        end else begin : g_multi_digit
            assign w_acc_next = {w_d, r_acc[WIDTH-1:DIGIT]};
        end
    endgenerate

    assign w_last = (r_cnt == c_last);

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Next-state and handshake output decode; outputs depend on state only.
    always_comb begin
        w_next    = r_state;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        case (r_state)
            ST_IDLE: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    w_next = ST_RUN;
                end
            end
            ST_RUN: begin
                if (w_last) begin
                    w_next = ST_DONE;
                end
            end
            ST_DONE: begin
                out_valid = 1'b1;
                if (out_ready) begin
                    w_next = ST_IDLE;
                end
            end
            default: begin
                w_next = ST_IDLE;
            end
        endcase
    end

    // Operand capture, per-digit subtraction and result publication.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_a      <= '0;
            r_b      <= '0;
            r_acc    <= '0;
            r_diff   <= '0;
            r_borrow <= 1'b0;
            r_bout   <= 1'b0;
            r_cnt    <= '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (in_valid) begin
                        r_a      <= a;
                        r_b      <= b;
                        r_borrow <= bin;
                        r_cnt    <= '0;
                    end
                end
                ST_RUN: begin
                    r_a      <= r_a >> DIGIT;
                    r_b      <= r_b >> DIGIT;
                    r_borrow <= w_bout_dig;
                    r_acc    <= w_acc_next;
                    if (w_last) begin
                        // Visible outputs only change once the full result exists.
                        r_diff <= w_acc_next;
                        r_bout <= w_bout_dig;
                    end else begin
                        r_cnt <= r_cnt + CW'(1);
                    end
                end
                default: begin
                end
            endcase
        end
    end

    assign diff = r_diff;
    assign bout = r_bout;

endmodule : pes_rcs
`default_nettype wire

// File: tb/tb_pes_rcs.sv
`default_nettype none
// ============================================================================
// Module      : tb_pes_rcs
// Description : Scoreboard bench for pes_rcs. A driver pushes the expected
//               difference for every accepted operand pair; a monitor pops
//               and compares whenever a result is presented.
// Revision    : 1.0 - initial release
// ============================================================================
import pes_arith_pkg::*;

module tb_pes_rcs;

    localparam int WIDTH = c_def_width;
    localparam int DIGIT = c_def_digit;
    localparam int NDIG  = WIDTH / DIGIT;

    typedef struct {
        logic [WIDTH-1:0] diff;
        logic             bout;
    } exp_t;

    logic             clk;
    logic             rst_n;
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             bin;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] diff;
    logic             bout;

    pes_rcs #(
        .WIDTH (WIDTH),
        .DIGIT (DIGIT)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .bin       (bin),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .diff      (diff),
        .bout      (bout)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;
    int cyc    = 0;

    exp_t sb[$];
    int   stamp[$];

    // Consumer readiness: either scripted by the main sequence or random.
    logic man_mode;
    logic man_rdy;
    logic rnd_rdy;
    int   rdy_pct;
    assign out_ready = man_mode ? man_rdy : rnd_rdy;

    always @(posedge clk) cyc <= cyc + 1;
    always @(negedge clk) rnd_rdy <= ($urandom_range(99) < rdy_pct);

    function automatic void check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, req, $time);
        end
    endfunction

    // Reference: plain integer subtraction; a negative result means a borrow out.
    function automatic exp_t model(input logic [WIDTH-1:0] va, input logic [WIDTH-1:0] vb, input logic vbin);
        exp_t e;
        int   dd;
        dd     = int'(va) - int'(vb) - int'(vbin);
        e.diff = dd[WIDTH-1:0];
        e.bout = (dd < 0);
        return e;
    endfunction

    task automatic send(input logic [WIDTH-1:0] va, input logic [WIDTH-1:0] vb, input logic vbin);
        int n;
        n = 0;
        @(negedge clk);
        a        = va;
        b        = vb;
        bin      = vbin;
        in_valid = 1'b1;
        while (!in_ready) begin
            @(negedge clk);
            n++;
            if (n > 200) begin
                check("accept_timeout", 32'd0, 32'd1);
                in_valid = 1'b0;
                return;
            end
        end
        sb.push_back(model(va, vb, vbin));
        stamp.push_back(cyc + 1);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    task automatic drain();
        int n;
        n = 0;
        while (sb.size() != 0 && n < 1000) begin
            @(negedge clk);
            n++;
        end
        if (sb.size() != 0) check("drain_timeout", 32'd0, 32'd1);
    endtask

    // Monitor: compares every presented result, latency and handoff behaviour.
    bit prev_valid = 1'b0;
    bit prev_hs    = 1'b0;
    initial begin
        forever begin
            @(negedge clk);
            #1;
            if (rst_n) begin
                if (prev_hs) begin
                    check("in_ready_after_handoff", 32'(in_ready), 32'd1);
                    check("out_valid_after_handoff", 32'(out_valid), 32'd0);
                end
                prev_hs = 1'b0;
                if (out_valid) begin
                    if (!prev_valid) begin
                        if (stamp.size() == 0) check("unexpected_out_valid", 32'd0, 32'd1);
                        else check("latency", 32'(cyc - stamp.pop_front()), 32'(NDIG));
                    end
                    check("in_ready_in_done", 32'(in_ready), 32'd0);
                    if (sb.size() == 0) begin
                        check("unexpected_result", 32'd0, 32'd1);
                    end else begin
                        check("diff", 32'(diff), 32'(sb[0].diff));
                        check("bout", 32'(bout), 32'(sb[0].bout));
                        if (out_ready) begin
                            void'(sb.pop_front());
                            prev_hs = 1'b1;
                        end
                    end
                end
                prev_valid = out_valid;
            end else begin
                prev_valid = 1'b0;
                prev_hs    = 1'b0;
            end
        end
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $fatal(1, "watchdog");
    end

    logic [WIDTH-1:0] dir_a [5] = '{16'h5678, 16'h1234, 16'h0000, 16'hABCD, 16'hFFFF};
    logic [WIDTH-1:0] dir_b [5] = '{16'h1234, 16'h5678, 16'h0000, 16'h9876, 16'hFFFF};
    logic             dir_c [5] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b0};

    initial begin
        rst_n    = 1'b0;
        in_valid = 1'b0;
        a        = '0;
        b        = '0;
        bin      = 1'b0;
        man_mode = 1'b1;
        man_rdy  = 1'b0;
        rdy_pct  = 100;
        #1;
        check("reset_in_ready", 32'(in_ready), 32'd1);
        check("reset_out_valid", 32'(out_valid), 32'd0);
        check("reset_diff", 32'(diff), 32'd0);
        check("reset_bout", 32'(bout), 32'd0);
        repeat (2) @(negedge clk);
        rst_n    = 1'b1;
        man_mode = 1'b0;

        // Directed vectors with an always-ready consumer.
        for (int i = 0; i < 5; i++) begin
            send(dir_a[i], dir_b[i], dir_c[i]);
            drain();
        end
        // Directed expectations independent of the reference model.
        check("known_abcd_9876", 32'(model(16'hABCD, 16'h9876, 1'b1).diff), 32'h1356);

        // Reset two cycles into RUN after a non-zero result is showing.
        send(16'h1234, 16'h5678, 1'b0);
        drain();
        send(16'h5678, 16'h1234, 1'b0);
        @(posedge clk);
        @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        check("rst_mid_run_out_valid", 32'(out_valid), 32'd0);
        check("rst_mid_run_in_ready", 32'(in_ready), 32'd1);
        check("rst_mid_run_diff", 32'(diff), 32'd0);
        check("rst_mid_run_bout", 32'(bout), 32'd0);
        sb.delete();
        stamp.delete();
        @(negedge clk);
        rst_n = 1'b1;
        send(16'h5678, 16'h1234, 1'b0);
        drain();

        // Backpressure: result held three cycles while new operands wait.
        man_rdy  = 1'b0;
        man_mode = 1'b1;
        send(16'h1234, 16'h5678, 1'b0);
        fork
            send(16'hABCD, 16'h9876, 1'b1);
            begin
                int n;
                n = 0;
                while (!out_valid && n < 50) begin
                    @(negedge clk);
                    n++;
                end
                if (!out_valid) check("bp_out_valid_timeout", 32'd0, 32'd1);
                repeat (3) @(negedge clk);
                man_rdy = 1'b1;
                @(negedge clk);
                man_rdy = 1'b0;
                @(posedge clk);
                #1;
                check("bp_pending_accepted", 32'(in_ready), 32'd0);
            end
        join
        man_mode = 1'b0;
        drain();

        // Random operands with a randomly stalling consumer.
        rdy_pct = 60;
        for (int i = 0; i < 150; i++) begin
            logic [WIDTH-1:0] ra;
            logic [WIDTH-1:0] rb;
            ra = WIDTH'($urandom);
            rb = WIDTH'($urandom);
            case ($urandom_range(7))
                0: rb = ra;
                1: ra = '0;
                2: rb = '1;
                default: ;
            endcase
            send(ra, rb, 1'($urandom_range(1)));
            repeat ($urandom_range(2)) @(negedge clk);
        end
        drain();
        repeat (4) @(negedge clk);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule : tb_pes_rcs
`default_nettype wire

// File: doc/pes_rcs.md
# pes_rcs

Multi-cycle 16-bit ripple-borrow subtractor: the inverse-direction companion to the `pes_rca` adder. It computes Diff = A − B − Bin and a borrow-out, processing DIGIT bits per clock from LSB to MSB, with the borrow carried between cycles in a flop. Operands enter and results leave through valid/ready handshakes. The block sits beside `pes_rca` in the datapath and in the regression suite, where the two check each other (A + B then back-subtracting).

## Interface
- WIDTH, 16, operand/result width; must be a multiple of DIGIT.
- DIGIT, 4, bits subtracted per cycle; NDIG = WIDTH/DIGIT.
- Clock  input  1  rising-edge clock.
- Reset_n  input  1  asynchronous active-low reset.
- In_valid  input  1  operands valid.
- In_ready  output  1  block can accept operands.
- A  input  WIDTH  minuend.
- B  input  WIDTH  subtrahend.
- Bin  input  1  borrow-in.
- Out_valid  output  1  Diff/Bout valid.
- Out_ready  input  1  consumer accepts result.
- Diff  output  WIDTH  (A − B − Bin) mod 2^WIDTH.
- Bout  output  1  1 iff A < B + Bin (unsigned).

## Operation
- Three states:
  - IDLE: In_ready=1, Out_valid=0.
  - RUN: both low.
  - DONE: Out_valid=1, In_ready=0.
- In IDLE, an edge with In_valid=1 is an accept:
  - Latches A, B and Bin into registers.
  - Clears the digit counter and goes to RUN.
- RUN, each cycle:
  - Subtracts the low DIGIT bits of the A and B registers minus the borrow flop: {borrow', d} = a_dig − b_dig − borrow.
  - Shifts the A/B registers right by DIGIT.
  - Shifts d into the result register from the top.
  - Increments the counter.
- After the NDIG-th RUN cycle, the result register holds Diff, the borrow flop holds Bout, and the state goes to DONE.
- DONE holds Diff/Bout stable until an edge with Out_ready=1, then returns to IDLE.
- Operand changes while not in IDLE are ignored.
- No accept can occur in the same cycle as result handoff. In_ready rises in the cycle after Out_valid&&Out_ready.
- Diff/Bout outputs are registered. They retain the last result in IDLE/RUN and are meaningful only when Out_valid=1.
- Counter width is clog2(NDIG). It never wraps during normal operation because the transition to DONE occurs at count NDIG−1.

## Timing
- Reset (Reset_n low, asynchronous, any state):
  - state=IDLE.
  - In_ready=1, Out_valid=0.
  - Diff=0, Bout=0.
  - Counter, borrow flop and operand registers all 0.
- Reset mid-RUN or mid-DONE discards the operation with no output.
- Latency: accept at edge E0 gives Out_valid=1 after edge E0+NDIG (4 cycles at defaults).
- Throughput: one result per NDIG+2 cycles when Out_ready is held high.
- In_valid and Out_ready are sampled only on rising edges. No combinational path exists from any input to any output.

## Structure
- Shared package/header `pes_arith_pkg`:
  - state encoding (IDLE=0, RUN=1, DONE=2).
  - default WIDTH/DIGIT constants, shared with `pes_rca` benches.
- One natural sub-module: `pes_digit_sub`, a combinational DIGIT-bit subtractor slice (a, b, bin → d, bout). It is instantiated once in `pes_rcs`.
- Elaboration check: WIDTH % DIGIT == 0, else $error.

## Test plan
- Reset mid-RUN:
  - Stimulus: accept 0x5678/0x1234, drop Reset_n at cycle 2.
  - Required: Out_valid=0, In_ready=1, Diff=0, Bout=0 immediately. A fresh accept after release completes normally.
- Basic subtraction, no borrow:
  - Stimulus: A=0x5678, B=0x1234, Bin=0.
  - Required: Diff=0x4444, Bout=0. Out_valid rises exactly 4 cycles after accept.
- Negative result:
  - Stimulus: A=0x1234, B=0x5678, Bin=0.
  - Required: Diff=0xBBBC, Bout=1.
- Full borrow ripple across every digit:
  - Stimulus: A=0x0000, B=0x0000, Bin=1.
  - Required: Diff=0xFFFF, Bout=1.
- Borrow-in with non-trivial operands:
  - Stimulus: A=0xABCD, B=0x9876, Bin=1.
  - Required: Diff=0x1356, Bout=0.
- Equal operands:
  - Stimulus: A=0xFFFF, B=0xFFFF, Bin=0.
  - Required: Diff=0x0000, Bout=0.
- Backpressure:
  - Stimulus: hold Out_ready=0 for 3 cycles in DONE, with In_valid=1 and new operands present.
  - Required: Diff/Bout/Out_valid stay stable and In_ready stays 0.
  - Then raise Out_ready for 1 cycle. Required: IDLE next cycle, and the pending operands are accepted on the following edge.
